// File: rtl/sw_result_pkg.sv
// Shared types and helpers for the Smith-Waterman result path.
package sw_result_pkg;

    typedef logic [17:0] score_t;

    localparam int unsigned RESULT_HISTORY_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } hist_state_e;

    // Next view slot, wrapping back to the newest entry after the oldest.
    function automatic logic [3:0] view_next(input logic [3:0] index, input logic [4:0] count);
        logic [4:0] bumped;
        bumped = {1'b0, index} + 5'd1;
        return (bumped >= count) ? 4'd0 : bumped[3:0];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a level and pulses for one cycle on its 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    // History resets high so a level already held during reset is not a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/result_history.sv
// Circular history of alignment scores with a key-stepped view.
// Optional running-maximum tracking is enabled by defining RESULT_HISTORY_MAX_EN.
module result_history
    import sw_result_pkg::*;
#(
    parameter int unsigned DEPTH = RESULT_HISTORY_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [17:0] i_result,
    input  logic        i_next,
    input  logic        i_clear,
    output logic [17:0] o_data,
    output logic [3:0]  o_index,
    output logic [4:0]  o_count,
    output logic [17:0] o_max,
    output logic        o_empty,
    output logic        o_full,
    output logic        o_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    score_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    hist_state_e     state;
    hist_state_e     state_next;
    logic            next_rise;
    logic            do_write;
    logic            do_step;
    logic [3:0]      step_index;
    logic [PW-1:0]   step_slot;

    rise_detect u_next_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (i_next),
        .pulse (next_rise)
    );

    // View slot k lives k entries behind the newest one at wr_ptr-1.
    assign step_index = view_next(o_index, o_count);
    assign step_slot  = wr_ptr - PW'(1) - PW'(step_index);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_step    = 1'b0;
        if (i_clear) begin
            state_next = S_EMPTY;
        end else if (i_valid) begin
            do_write = 1'b1;
            case (state)
                S_EMPTY: state_next = S_FILL;
                S_FILL:  if (o_count == 5'(DEPTH - 1)) state_next = S_FULL;
                default: state_next = state;
            endcase
        end else if (next_rise && (state != S_EMPTY)) begin
            do_step = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem[wr_ptr] <= i_result;
        end
    end

    // Overflow is sticky until reset; clearing the history leaves it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            o_index    <= '0;
            o_count    <= '0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            wr_ptr  <= '0;
            o_index <= '0;
            o_count <= '0;
            o_data  <= '0;
        end else if (do_write) begin
            wr_ptr  <= wr_ptr + PW'(1);
            o_index <= '0;
            o_data  <= i_result;
            if (state == S_FULL) begin
                o_overflow <= 1'b1;
            end else begin
                o_count <= o_count + 5'd1;
            end
        end else if (do_step) begin
            o_index <= step_index;
            o_data  <= mem[step_slot];
        end
    end

    assign o_empty = (state == S_EMPTY);
    assign o_full  = (state == S_FULL);

`ifdef RESULT_HISTORY_MAX_EN
    score_t max_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (i_clear) begin
            max_q <= '0;
        end else if (do_write && (i_result > max_q)) begin
            max_q <= i_result;
        end
    end

    assign o_max = max_q;
`else
    assign o_max = '0;
`endif

endmodule

// File: tb/tb_result_history.sv
// Self-checking bench for result_history against a queue-based history model.
module tb_result_history;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [17:0] i_result;
    logic        i_next;
    logic        i_clear;
    logic [17:0] o_data;
    logic [3:0]  o_index;
    logic [4:0]  o_count;
    logic [17:0] o_max;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;

    always #5 clk = ~clk;

    result_history #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_next     (i_next),
        .i_clear    (i_clear),
        .o_data     (o_data),
        .o_index    (o_index),
        .o_count    (o_count),
        .o_max      (o_max),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: newest score at the front of the queue.
    logic [17:0] hist[$];
    int unsigned m_idx  = 0;
    logic [17:0] m_max  = '0;
    bit          m_ovf  = 1'b0;
    bit          m_prev = 1'b1;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_data();
        return (hist.size() == 0) ? 18'd0 : hist[m_idx];
    endfunction

    function automatic logic [17:0] exp_max();
`ifdef RESULT_HISTORY_MAX_EN
        return m_max;
`else
        return 18'd0;
`endif
    endfunction

    task automatic model_step();
        bit rise;
        if (!rst_n) begin
            hist.delete();
            m_idx  = 0;
            m_max  = '0;
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            rise = i_next && !m_prev;
            if (i_clear) begin
                hist.delete();
                m_idx = 0;
                m_max = '0;
            end else if (i_valid) begin
                hist.push_front(i_result);
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_back());
                    m_ovf = 1'b1;
                end
                m_idx = 0;
                if (i_result > m_max) m_max = i_result;
            end else if (rise && hist.size() > 0) begin
                m_idx = (m_idx + 1) % hist.size();
            end
            m_prev = i_next;
        end
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [17:0] r, input bit n, input bit c);
        rst_n    = rst;
        i_valid  = v;
        i_result = r;
        i_next   = n;
        i_clear  = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("data",     32'(o_data),     32'(exp_data()));
            chk("index",    32'(o_index),    32'(m_idx));
            chk("count",    32'(o_count),    32'(hist.size()));
            chk("empty",    32'(o_empty),    32'(hist.size() == 0));
            chk("full",     32'(o_full),     32'(hist.size() == DEPTH));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("max",      32'(o_max),      32'(exp_max()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] exp_seq [3];
        logic [3:0]  idx_seq [3];
        bit          lvl;
        exp_seq = '{18'd9, 18'd5, 18'd3};
        idx_seq = '{4'd1, 4'd2, 4'd0};

        cyc(0, 0, 0, 0, 0);
        model_on = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_data",  32'(o_data),  0);
        chk("rst_full",  32'(o_full),  0);

        // Basic writes.
        cyc(1, 1, 18'd5, 0, 0);
        cyc(1, 1, 18'd9, 0, 0);
        cyc(1, 1, 18'd3, 0, 0);
        chk("basic_count", 32'(o_count), 3);
        chk("basic_data",  32'(o_data),  3);
        chk("basic_index", 32'(o_index), 0);
        chk("basic_empty", 32'(o_empty), 0);
`ifdef RESULT_HISTORY_MAX_EN
        chk("basic_max", 32'(o_max), 9);
`else
        chk("basic_max", 32'(o_max), 0);
`endif

        // View stepping; a held key counts once.
        for (int unsigned k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1, 0);
            chk("step_data",  32'(o_data),  32'(exp_seq[k]));
            chk("step_index", 32'(o_index), 32'(idx_seq[k]));
            cyc(1, 0, 0, 1, 0);
            chk("held_index", 32'(o_index), 32'(idx_seq[k]));
            cyc(1, 0, 0, 0, 0);
        end

        // Wrap-around.
        cyc(1, 0, 0, 0, 1);
        chk("clear_count", 32'(o_count), 0);
        for (int unsigned k = 1; k <= 10; k++) cyc(1, 1, 18'(k), 0, 0);
        chk("wrap_count", 32'(o_count),    8);
        chk("wrap_full",  32'(o_full),     1);
        chk("wrap_ovf",   32'(o_overflow), 1);
        chk("wrap_new",   32'(o_data),     10);
        for (int unsigned k = 0; k < 7; k++) begin
            cyc(1, 0, 0, 1, 0);
            cyc(1, 0, 0, 0, 0);
        end
        chk("wrap_old_index", 32'(o_index), 7);
        chk("wrap_old_data",  32'(o_data),  3);

        // Coinciding events.
        cyc(1, 1, 18'd7, 1, 0);
        chk("coin_index", 32'(o_index), 0);
        chk("coin_data",  32'(o_data),  7);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 18'd12, 0, 1);
        chk("vclr_count", 32'(o_count), 0);
        chk("vclr_data",  32'(o_data),  0);

        // Reset mid-operation with the key held.
        for (int unsigned k = 0; k < 4; k++) cyc(1, 1, 18'(20 + k), 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 18'd99, 1, 0);
        chk("mrst_count", 32'(o_count),    0);
        chk("mrst_data",  32'(o_data),     0);
        chk("mrst_ovf",   32'(o_overflow), 0);
        chk("mrst_empty", 32'(o_empty),    1);
        chk("mrst_max",   32'(o_max),      0);
        cyc(1, 1, 18'd4, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("mrst_hold_index", 32'(o_index), 0);
        chk("mrst_hold_data",  32'(o_data),  4);
        cyc(1, 0, 0, 0, 0);

        // Configuration-dependent maximum.
        cyc(1, 1, 18'h3FFFF, 0, 0);
        chk("cfg_data",  32'(o_data),  32'h3FFFF);
        chk("cfg_count", 32'(o_count), 2);
`ifdef RESULT_HISTORY_MAX_EN
        chk("cfg_max", 32'(o_max), 32'h3FFFF);
`else
        chk("cfg_max", 32'(o_max), 0);
`endif

        // Randomized traffic.
        lvl = 1'b0;
        for (int unsigned k = 0; k < 4000; k++) begin
            bit          rst, v, c;
            logic [17:0] r;
            rst = ($urandom_range(0, 249) != 0);
            v   = ($urandom_range(0, 2) == 0);
            c   = ($urandom_range(0, 59) == 0);
            r   = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(0, 15)) : 18'($urandom);
            if ($urandom_range(0, 2) == 0) lvl = ~lvl;
            cyc(rst, v, r, lvl, c);
        end

        cyc(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
